// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants, MEM-stage FSM state and pipeline register layouts
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic              regWrite;
        logic              memToReg;
        logic              memRead;
        logic              memWrite;
        logic [REG_W-1:0]  dest;
        logic [DATA_W-1:0] res;
        logic [DATA_W-1:0] bout;
    } exmem_t;

    typedef struct packed {
        logic              regWrite;
        logic              memToReg;
        logic [REG_W-1:0]  dest;
        logic [DATA_W-1:0] res;
        logic [DATA_W-1:0] rdata;
    } memwb_t;

endpackage

// File: rtl/dmem_handshake.sv
// rtl/dmem_handshake.sv - data memory req/ack FSM with outstanding-access timeout
module dmem_handshake #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic memOp,
    input  logic ack,
    output logic req,
    output logic done,
    output logic abort
);
    import mips_pkg::*;

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    mem_state_t    state;
    logic [CW-1:0] wcnt;
    logic          atLimit;

    // wcnt counts cycles the request has been outstanding, the IDLE issue cycle being cycle 0
    always_comb begin
        atLimit = 1'b0;
        if (state == IDLE) begin
            atLimit = (TIMEOUT_CYC == 1);
        end else begin
            atLimit = (wcnt == CW'(TIMEOUT_CYC - 1));
        end
    end

    assign req   = memOp;
    assign done  = memOp & (ack | atLimit);
    assign abort = memOp & ~ack & atLimit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            wcnt  <= '0;
        end else if (!memOp || ack || atLimit) begin
            state <= IDLE;
            wcnt  <= '0;
        end else begin
            state <= WAIT;
            wcnt  <= wcnt + CW'(1);
        end
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS MEM stage: EX/MEM and MEM/WB registers, dmem handshake, stall
// Optional ALIGN_CHECK_EN: misaligned memory ops become bubbles and pulse misalign.
module mem_stage #(
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic              memToReg,
    input  logic              regWrite,
    input  logic [4:0]        destIn,
    input  logic [DATA_W-1:0] res,
    input  logic [DATA_W-1:0] Bout,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              regWriteMEM,
    output logic [4:0]        destInMEM,
    output logic [DATA_W-1:0] forwardedA,
    output logic              regWriteWB,
    output logic [4:0]        destInWB,
    output logic [DATA_W-1:0] forwardedB,
    output logic              bus_err
`ifdef ALIGN_CHECK_EN
    ,
    output logic              misalign
`endif
);
    import mips_pkg::*;

    exmem_t exmem;
    memwb_t memwb;
    logic   memOpRaw;
    logic   memOp;
    logic   misaligned;
    logic   hsReq;
    logic   hsDone;
    logic   abort;

    assign memOpRaw = exmem.memRead | exmem.memWrite;

`ifdef ALIGN_CHECK_EN
    assign misaligned = memOpRaw & (exmem.res[1:0] != 2'b00);
    assign misalign   = misaligned;
`else
    assign misaligned = 1'b0;
`endif

    assign memOp = memOpRaw & ~misaligned;

    dmem_handshake #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_handshake (
        .clk  (clk),
        .rst  (rst),
        .memOp(memOp),
        .ack  (dmem_ack),
        .req  (hsReq),
        .done (hsDone),
        .abort(abort)
    );

    assign dmem_req   = hsReq;
    assign stall      = hsReq & ~hsDone;
    assign dmem_we    = exmem.memWrite;
    assign dmem_addr  = exmem.res;
    assign dmem_wdata = exmem.bout;

    assign regWriteMEM = exmem.regWrite;
    assign destInMEM   = exmem.dest;
    assign forwardedA  = exmem.res;
    assign regWriteWB  = memwb.regWrite;
    assign destInWB    = memwb.dest;
    assign forwardedB  = memwb.memToReg ? memwb.rdata : memwb.res;

    always_ff @(posedge clk) begin
        if (rst) begin
            exmem   <= '0;
            memwb   <= '0;
            bus_err <= 1'b0;
        end else begin
            if (!stall) begin
                exmem.regWrite <= regWrite;
                exmem.memToReg <= memToReg;
                exmem.memRead  <= memRead;
                exmem.memWrite <= memWrite;
                exmem.dest     <= destIn;
                exmem.res      <= res;
                exmem.bout     <= Bout;
            end
            // Stalled, aborted and misaligned ops all retire as bubbles
            if (stall || abort || misaligned) begin
                memwb <= '0;
            end else begin
                memwb.regWrite <= exmem.regWrite;
                memwb.memToReg <= exmem.memToReg;
                memwb.dest     <= exmem.dest;
                memwb.res      <= exmem.res;
                memwb.rdata    <= (hsReq && dmem_ack && exmem.memRead && !exmem.memWrite)
                                  ? dmem_rdata : '0;
            end
            if (abort) begin
                bus_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - randomized scoreboard bench for mem_stage with a memory responder
module tb_mem_stage;
    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        memRead, memWrite, memToReg, regWrite;
    logic [4:0]  destIn;
    logic [31:0] res, Bout;
    logic        stall, dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        regWriteMEM, regWriteWB, bus_err;
    logic [4:0]  destInMEM, destInWB;
    logic [31:0] forwardedA, forwardedB;
`ifdef ALIGN_CHECK_EN
    logic        misalign;
`endif

    always #5 clk = ~clk;

    mem_stage #(.DATA_W(32), .TIMEOUT_CYC(T)) dut (
        .clk(clk), .rst(rst), .memRead(memRead), .memWrite(memWrite), .memToReg(memToReg),
        .regWrite(regWrite), .destIn(destIn), .res(res), .Bout(Bout), .stall(stall),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .regWriteMEM(regWriteMEM),
        .destInMEM(destInMEM), .forwardedA(forwardedA), .regWriteWB(regWriteWB),
        .destInWB(destInWB), .forwardedB(forwardedB), .bus_err(bus_err)
`ifdef ALIGN_CHECK_EN
        , .misalign(misalign)
`endif
    );

    typedef struct { logic rd, wr, m2r, rw; logic [4:0] dest; logic [31:0] res, bout, rdata; int delay; } op_t;
    typedef struct { logic [4:0] dest; logic [31:0] val; } wb_t;
    typedef struct { int delay; logic [31:0] rdata; } mem_t;

    op_t  ops[$];
    wb_t  wbQ[$];
    mem_t memQ[$];
    int   checks = 0;
    int   errors = 0;
    int   expStall = 0;
    int   actStall = 0;
    logic expBusErr = 1'b0;
    bit   monOn = 1'b0;
    bit   active = 1'b0;
    int   cnt = 0;
    mem_t cur;
    wb_t  e;
    logic        prevStall = 1'b0;
    logic        pWe;
    logic [31:0] pAddr, pWdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pops one expected write per retired register write
    always @(negedge clk) begin
        #2;
        if (monOn) begin
            if (regWriteWB) begin
                if (wbQ.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wb_unexpected: got write to r%0d expected none", destInWB);
                end else begin
                    e = wbQ.pop_front();
                    check("wb_dest", {27'd0, destInWB}, {27'd0, e.dest});
                    check("wb_val", forwardedB, e.val);
                end
            end
            if (prevStall) begin
                check("req_hold", {31'd0, dmem_req}, 32'd1);
                check("we_hold", {31'd0, dmem_we}, {31'd0, pWe});
                check("addr_hold", dmem_addr, pAddr);
                check("wdata_hold", dmem_wdata, pWdata);
            end
            prevStall = stall;
            pWe = dmem_we; pAddr = dmem_addr; pWdata = dmem_wdata;
        end
    end

    // Memory responder: each request acks after its chosen delay; garbage rdata otherwise
    task automatic respond();
        dmem_ack = 1'b0;
        dmem_rdata = $urandom;
        if (dmem_req) begin
            if (!active) begin
                if (memQ.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_req: got request at %h expected none", dmem_addr);
                    cur.delay = 0; cur.rdata = 32'd0;
                end else begin
                    cur = memQ.pop_front();
                end
                cnt = 0;
                active = 1'b1;
            end
            if (cnt == cur.delay) begin
                dmem_ack = 1'b1;
                dmem_rdata = cur.rdata;
                active = 1'b0;
            end else if (cnt == T - 1) begin
                active = 1'b0;
            end
            cnt++;
        end
    endtask

    task automatic model(input op_t o);
        bit isMem;
        logic [31:0] v;
        isMem = o.rd | o.wr;
        if (isMem) memQ.push_back('{o.delay, o.rdata});
        if (isMem && o.delay >= T) begin
            expBusErr = 1'b1;
            expStall += T - 1;
        end else begin
            if (isMem) expStall += o.delay;
            v = o.m2r ? ((o.rd && !o.wr) ? o.rdata : 32'd0) : o.res;
            if (o.rw) wbQ.push_back('{o.dest, v});
        end
    endtask

    task automatic cycle(input op_t o, output bit accepted);
        @(negedge clk);
        respond();
        memRead = o.rd; memWrite = o.wr; memToReg = o.m2r; regWrite = o.rw;
        destIn = o.dest; res = o.res; Bout = o.bout;
        #1;
        if (stall) actStall++;
        accepted = !stall;
        if (accepted) model(o);
    endtask

    task automatic issue(input op_t o);
        bit acc;
        int tries;
        tries = 0;
        acc = 1'b0;
        while (!acc && tries < 40) begin
            cycle(o, acc);
            tries++;
        end
        if (!acc) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got stall for %0d cycles expected acceptance", tries);
        end
    endtask

    function automatic op_t mk(input logic rd, wr, m2r, rw, input logic [4:0] dest,
                               input logic [31:0] r, b, rdata, input int delay);
        op_t o;
        o.rd = rd; o.wr = wr; o.m2r = m2r; o.rw = rw; o.dest = dest;
        o.res = r; o.bout = b; o.rdata = rdata; o.delay = delay;
        return o;
    endfunction

    function automatic op_t randOp();
        op_t o;
        int k;
        k = $urandom_range(0, 9);
        o.rd = (k < 3) || (k == 5);
        o.wr = (k >= 3 && k <= 5);
        o.m2r = o.rd ? 1'b1 : ($urandom_range(0, 3) == 0);
        o.rw = (k == 3 || k == 4) ? ($urandom_range(0, 3) == 0) : 1'b1;
        o.dest = 5'($urandom);
        o.res = $urandom;
        if (o.rd || o.wr) o.res[1:0] = 2'b00;
        o.bout = $urandom;
        o.rdata = $urandom;
        o.delay = ($urandom_range(0, 7) == 0) ? 99 : int'($urandom_range(0, 3));
        return o;
    endfunction

    op_t nop;
    int  s0;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nop = mk(0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0, 0);
        rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'd0;
        memRead = 0; memWrite = 0; memToReg = 0; regWrite = 0;
        destIn = 0; res = 0; Bout = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_req", {31'd0, dmem_req}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_rwwb", {31'd0, regWriteWB}, 32'd0);
        check("rst_buserr", {31'd0, bus_err}, 32'd0);
        check("rst_fwdB", forwardedB, 32'd0);
        check("rst_fwdA", forwardedA, 32'd0);
        monOn = 1'b1;

        issue(mk(0, 0, 0, 1, 5'd5, 32'h10, 32'd0, 32'd0, 0));
        issue(nop);
        issue(nop);
        check("alu_dest", {27'd0, destInWB}, 32'd5);
        check("alu_val", forwardedB, 32'h10);

        issue(mk(1, 0, 1, 1, 5'd6, 32'h40, 32'd0, 32'hDEADBEEF, 0));
        issue(nop);
        check("zw_stall", {31'd0, stall}, 32'd0);
        issue(nop);
        check("zw_val", forwardedB, 32'hDEADBEEF);

        s0 = actStall;
        issue(mk(0, 1, 0, 0, 5'd0, 32'h80, 32'h1234, 32'd0, 3));
        repeat (6) issue(nop);
        check("st_stalls", actStall - s0, 32'd3);
        check("st_rwwb", {31'd0, regWriteWB}, 32'd0);

        s0 = actStall;
        issue(mk(1, 0, 1, 1, 5'd9, 32'h100, 32'd0, 32'h55, 99));
        repeat (6) issue(nop);
        check("to_stalls", actStall - s0, T - 1);
        check("to_buserr", {31'd0, bus_err}, 32'd1);

        for (int i = 0; i < 150; i++) issue(randOp());
        repeat (T + 6) issue(nop);

        check("end_wbq", wbQ.size(), 32'd0);
        check("end_memq", memQ.size(), 32'd0);
        check("end_stalls", actStall, expStall);
        check("end_buserr", {31'd0, bus_err}, {31'd0, expBusErr});

        issue(mk(1, 0, 1, 1, 5'd3, 32'h200, 32'd0, 32'h77, 99));
        issue(nop);
        issue(nop);
        monOn = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #1;
        rst = 1'b0;
        check("rw_req", {31'd0, dmem_req}, 32'd0);
        check("rw_stall", {31'd0, stall}, 32'd0);
        check("rw_buserr", {31'd0, bus_err}, 32'd0);
        check("rw_rwmem", {31'd0, regWriteMEM}, 32'd0);
        check("rw_fwdA", forwardedA, 32'd0);
        dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
        memRead = 0; memWrite = 0; regWrite = 0; memToReg = 0;
        @(negedge clk);
        #1;
        dmem_ack = 1'b0;
        check("late_req", {31'd0, dmem_req}, 32'd0);
        check("late_rwwb", {31'd0, regWriteWB}, 32'd0);
        check("late_fwdB", forwardedB, 32'd0);
        active = 1'b0;

`ifdef ALIGN_CHECK_EN
        memRead = 1; memToReg = 1; regWrite = 1; destIn = 5'd7; res = 32'h42;
        @(negedge clk);
        memRead = 0; memToReg = 0; regWrite = 0; res = 32'd0;
        #1;
        check("al_req", {31'd0, dmem_req}, 32'd0);
        check("al_mis", {31'd0, misalign}, 32'd1);
        check("al_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        #1;
        check("al_mis_end", {31'd0, misalign}, 32'd0);
        check("al_rwwb", {31'd0, regWriteWB}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
